// File: rtl/xgriscv_run_monitor.sv
// Run-control monitor for the xgriscv core: watches the fetch PC and decides when a run ends
// (end address, self-loop halt or cycle budget), with activity counters and a PC history ring.
module xgriscv_run_monitor #(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 8,
    parameter int HIST_DEPTH  = 8,
    localparam int IDX_W      = $clog2(HIST_DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    input  logic [CNT_W-1:0]  max_cycles_i,
    input  logic [IDX_W-1:0]  hist_idx_i,
    output logic              done_o,
    output logic [1:0]        status_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [CNT_W-1:0]  pc_chg_cnt_o,
    output logic [ADDR_W-1:0] last_pc_o,
    output logic [ADDR_W-1:0] hist_pc_o,
    output logic [IDX_W:0]    hist_cnt_o
);

    // state        | meaning
    // RUN          | accepting valid PC samples, evaluating halt conditions
    // HALT_END     | PC reached end_addr_i (terminal until reset)
    // HALT_LOOP    | PC repeated STALL_LIMIT times in a row (terminal)
    // HALT_TIMEOUT | accepted-sample budget exhausted (terminal)
    typedef enum logic [1:0] {
        RUN          = 2'b00,
        HALT_END     = 2'b01,
        HALT_LOOP    = 2'b10,
        HALT_TIMEOUT = 2'b11
    } state_t;

    localparam int REP_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [REP_W-1:0] REP_LIMIT = REP_W'(STALL_LIMIT);
    localparam logic [IDX_W:0]   HIST_FULL = (IDX_W+1)'(HIST_DEPTH);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cycle_cnt, pc_chg_cnt;
    logic [CNT_W-1:0]   cyc_nxt, chg_nxt;
    logic [REP_W-1:0]   rep_cnt, rep_nxt;
    logic [ADDR_W-1:0]  last_pc;
    logic               first;
    logic               accept, is_chg;
    logic [ADDR_W-1:0]  hist [HIST_DEPTH];
    logic [IDX_W-1:0]   wp, rd_ptr;
    logic [IDX_W:0]     hist_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) state <= RUN;
        else       state <= state_nxt;
    end

    // Halt checks look at the post-update counters of the same sample.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        is_chg    = 1'b0;
        cyc_nxt   = cycle_cnt;
        chg_nxt   = pc_chg_cnt;
        rep_nxt   = rep_cnt;
        if (state == RUN && pc_valid_i) begin
            accept  = 1'b1;
            is_chg  = first || (pc_i != last_pc);
            cyc_nxt = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
            if (is_chg) begin
                chg_nxt = (pc_chg_cnt == '1) ? pc_chg_cnt : pc_chg_cnt + CNT_W'(1);
                rep_nxt = '0;
            end else begin
                rep_nxt = (rep_cnt == REP_LIMIT) ? rep_cnt : rep_cnt + REP_W'(1);
            end
            if (pc_i == end_addr_i)
                state_nxt = HALT_END;
            else if (rep_nxt == REP_LIMIT)
                state_nxt = HALT_LOOP;
            else if (max_cycles_i != '0 && cyc_nxt == max_cycles_i)
                state_nxt = HALT_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycle_cnt  <= '0;
            pc_chg_cnt <= '0;
            rep_cnt    <= '0;
            last_pc    <= '0;
            first      <= 1'b1;
            wp         <= '0;
            hist_cnt   <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
        end else if (accept) begin
            cycle_cnt  <= cyc_nxt;
            pc_chg_cnt <= chg_nxt;
            rep_cnt    <= rep_nxt;
            last_pc    <= pc_i;
            first      <= 1'b0;
            if (is_chg) begin
                hist[wp] <= pc_i;
                wp       <= wp + IDX_W'(1);
                if (hist_cnt != HIST_FULL) hist_cnt <= hist_cnt + (IDX_W+1)'(1);
            end
        end
    end

    // Index 0 is the newest entry; wp points one past it and wraps naturally.
    assign rd_ptr = wp - IDX_W'(1) - hist_idx_i;

    always_comb begin
        hist_pc_o = '0;
        if ({1'b0, hist_idx_i} < hist_cnt) hist_pc_o = hist[rd_ptr];
    end

    assign done_o       = (state != RUN);
    assign status_o     = state;
    assign cycle_cnt_o  = cycle_cnt;
    assign pc_chg_cnt_o = pc_chg_cnt;
    assign last_pc_o    = last_pc;
    assign hist_cnt_o   = hist_cnt;

endmodule

// File: tb/tb_xgriscv_run_monitor.sv
// Bench for xgriscv_run_monitor: directed scenarios plus randomized runs checked against
// a queue-based behavioural model of the run rules.
module tb_xgriscv_run_monitor;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;
    localparam int SL     = 4;
    localparam int HD     = 8;
    localparam logic [31:0] NO_END = 32'hFFFF_FFF0;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [ADDR_W-1:0] pc_i = '0;
    logic              pc_valid_i = 1'b0;
    logic [ADDR_W-1:0] end_addr_i = NO_END;
    logic [CNT_W-1:0]  max_cycles_i = '0;
    logic [2:0]        hist_idx_i = '0;
    logic              done_o;
    logic [1:0]        status_o;
    logic [CNT_W-1:0]  cycle_cnt_o, pc_chg_cnt_o;
    logic [ADDR_W-1:0] last_pc_o, hist_pc_o;
    logic [3:0]        hist_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    xgriscv_run_monitor #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .STALL_LIMIT(SL), .HIST_DEPTH(HD)
    ) dut (
        .clk(clk), .rstn(rstn), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
        .end_addr_i(end_addr_i), .max_cycles_i(max_cycles_i), .hist_idx_i(hist_idx_i),
        .done_o(done_o), .status_o(status_o), .cycle_cnt_o(cycle_cnt_o),
        .pc_chg_cnt_o(pc_chg_cnt_o), .last_pc_o(last_pc_o), .hist_pc_o(hist_pc_o),
        .hist_cnt_o(hist_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: run outcome, counters, and history as a newest-first queue.
    int unsigned m_status, m_cyc, m_chg, m_last, m_rep;
    bit          m_first;
    logic [31:0] m_hist[$];

    function automatic void model_reset();
        m_status = 0; m_cyc = 0; m_chg = 0; m_last = 0; m_rep = 0; m_first = 1;
        m_hist.delete();
    endfunction

    function automatic void model_step(input logic [31:0] pc, input bit v);
        if (m_status != 0 || !v) return;
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (m_first || pc != m_last) begin
            if (m_chg != 32'hFFFF_FFFF) m_chg++;
            m_hist.push_front(pc);
            if (m_hist.size() > HD) void'(m_hist.pop_back());
            m_rep = 0;
        end else if (m_rep < SL) begin
            m_rep++;
        end
        m_first = 0;
        m_last  = pc;
        if (pc == end_addr_i)                            m_status = 1;
        else if (m_rep == SL)                            m_status = 2;
        else if (max_cycles_i != 0 && m_cyc == max_cycles_i) m_status = 3;
    endfunction

    function automatic logic [31:0] model_hist(input int idx);
        return (idx < m_hist.size()) ? m_hist[idx] : 32'h0;
    endfunction

    task automatic do_reset();
        rstn = 1'b0; pc_valid_i = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic [31:0] pc, input bit v);
        pc_i = pc; pc_valid_i = v;
        @(posedge clk); #1;
        model_step(pc, v);
    endtask

    task automatic test_reset();
        rstn = 1'b0; pc_i = 32'h40; pc_valid_i = 1'b1; hist_idx_i = 3'd0;
        @(posedge clk); #1;
        n_checks++;
        if ({done_o, status_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status: got done=%0b status=%0b want 0/00", done_o, status_o);
        end
        n_checks++;
        if (cycle_cnt_o !== 0 || pc_chg_cnt_o !== 0 || last_pc_o !== 0) begin
            n_fail++; $display("FAIL reset_counters: got cyc=%0d chg=%0d last=%h want 0/0/0",
                               cycle_cnt_o, pc_chg_cnt_o, last_pc_o);
        end
        n_checks++;
        if (hist_cnt_o !== 0 || hist_pc_o !== 0) begin
            n_fail++; $display("FAIL reset_hist: got cnt=%0d pc=%h want 0/0", hist_cnt_o, hist_pc_o);
        end
        rstn = 1'b1; pc_valid_i = 1'b0;
        model_reset();
    endtask

    task automatic test_end_hit();
        end_addr_i = 32'h1C; max_cycles_i = 0;
        do_reset();
        for (int i = 0; i < 8; i++) step(32'(i * 4), 1'b1);
        n_checks++;
        if (done_o !== 1'b1 || status_o !== 2'b01) begin
            n_fail++; $display("FAIL end_status: got done=%0b status=%0b want 1/01", done_o, status_o);
        end
        n_checks++;
        if (cycle_cnt_o !== 8 || pc_chg_cnt_o !== 8 || last_pc_o !== 32'h1C) begin
            n_fail++; $display("FAIL end_counters: got cyc=%0d chg=%0d last=%h want 8/8/1c",
                               cycle_cnt_o, pc_chg_cnt_o, last_pc_o);
        end
        for (int i = 0; i < 3; i++) step(32'h200 + 32'(i * 4), 1'b1);
        n_checks++;
        if (cycle_cnt_o !== 8 || pc_chg_cnt_o !== 8 || last_pc_o !== 32'h1C ||
            status_o !== 2'b01 || hist_cnt_o !== 8) begin
            n_fail++; $display("FAIL end_frozen: got cyc=%0d chg=%0d last=%h st=%0b hcnt=%0d want 8/8/1c/01/8",
                               cycle_cnt_o, pc_chg_cnt_o, last_pc_o, status_o, hist_cnt_o);
        end
    endtask

    task automatic test_loop_halt();
        logic [31:0] seq [6];
        seq = '{32'h10, 32'h14, 32'h14, 32'h14, 32'h14, 32'h14};
        end_addr_i = NO_END; max_cycles_i = 0;
        do_reset();
        for (int i = 0; i < 5; i++) step(seq[i], 1'b1);
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++; $display("FAIL loop_early: got done=%0b after 5 samples want 0", done_o);
        end
        step(seq[5], 1'b1);
        n_checks++;
        if (status_o !== 2'b10 || done_o !== 1'b1 || cycle_cnt_o !== 6 || pc_chg_cnt_o !== 2) begin
            n_fail++; $display("FAIL loop_halt: got st=%0b done=%0b cyc=%0d chg=%0d want 10/1/6/2",
                               status_o, done_o, cycle_cnt_o, pc_chg_cnt_o);
        end
    endtask

    task automatic test_timeout_bubbles();
        end_addr_i = NO_END; max_cycles_i = 5;
        do_reset();
        step(32'h0, 1'b1);
        step(32'h4, 1'b1);
        for (int i = 0; i < 3; i++) step(32'h8, 1'b0);
        n_checks++;
        if (cycle_cnt_o !== 2 || last_pc_o !== 32'h4 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL bubble_ignored: got cyc=%0d last=%h done=%0b want 2/4/0",
                               cycle_cnt_o, last_pc_o, done_o);
        end
        step(32'h8, 1'b1);
        step(32'hC, 1'b1);
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: got done=%0b after 4 samples want 0", done_o);
        end
        step(32'h10, 1'b1);
        n_checks++;
        if (status_o !== 2'b11 || cycle_cnt_o !== 5) begin
            n_fail++; $display("FAIL timeout: got st=%0b cyc=%0d want 11/5", status_o, cycle_cnt_o);
        end
    endtask

    task automatic test_priority();
        end_addr_i = 32'h08; max_cycles_i = 3;
        do_reset();
        step(32'h0, 1'b1); step(32'h4, 1'b1); step(32'h8, 1'b1);
        n_checks++;
        if (status_o !== 2'b01 || cycle_cnt_o !== 3) begin
            n_fail++; $display("FAIL priority: got st=%0b cyc=%0d want 01/3", status_o, cycle_cnt_o);
        end
    endtask

    task automatic test_history_wrap();
        end_addr_i = NO_END; max_cycles_i = 0;
        do_reset();
        for (int i = 0; i < 10; i++) step(32'h100 + 32'(i * 4), 1'b1);
        n_checks++;
        if (hist_cnt_o !== 8 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL hist_cnt: got cnt=%0d done=%0b want 8/0", hist_cnt_o, done_o);
        end
        hist_idx_i = 3'd0; #1;
        n_checks++;
        if (hist_pc_o !== 32'h124) begin
            n_fail++; $display("FAIL hist_newest: got %h want 124", hist_pc_o);
        end
        hist_idx_i = 3'd7; #1;
        n_checks++;
        if (hist_pc_o !== 32'h108) begin
            n_fail++; $display("FAIL hist_oldest: got %h want 108", hist_pc_o);
        end
        do_reset();
        step(32'h300, 1'b1); step(32'h304, 1'b1); step(32'h304, 1'b1);
        for (int i = 0; i < HD; i++) begin
            hist_idx_i = 3'(i); #1;
            n_checks++;
            if (hist_pc_o !== model_hist(i)) begin
                n_fail++; $display("FAIL hist_partial[%0d]: got %h want %h", i, hist_pc_o, model_hist(i));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        end_addr_i = NO_END; max_cycles_i = 0;
        do_reset();
        step(32'h40, 1'b1); step(32'h44, 1'b1); step(32'h48, 1'b1);
        rstn = 1'b0; pc_i = 32'h4C; pc_valid_i = 1'b1; hist_idx_i = 3'd0;
        @(posedge clk); #1;
        n_checks++;
        if (done_o !== 0 || status_o !== 0 || cycle_cnt_o !== 0 || pc_chg_cnt_o !== 0 ||
            last_pc_o !== 0 || hist_cnt_o !== 0 || hist_pc_o !== 0) begin
            n_fail++; $display("FAIL midrun_reset: got done=%0b st=%0b cyc=%0d chg=%0d last=%h hcnt=%0d hpc=%h want all 0",
                               done_o, status_o, cycle_cnt_o, pc_chg_cnt_o, last_pc_o, hist_cnt_o, hist_pc_o);
        end
        rstn = 1'b1;
        model_reset();
        step(32'h48, 1'b1);
        n_checks++;
        if (cycle_cnt_o !== 1 || pc_chg_cnt_o !== 1 || last_pc_o !== 32'h48) begin
            n_fail++; $display("FAIL midrun_first: got cyc=%0d chg=%0d last=%h want 1/1/48",
                               cycle_cnt_o, pc_chg_cnt_o, last_pc_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        int          idx;
        for (int run = 0; run < 12; run++) begin
            end_addr_i   = ($urandom_range(0, 2) == 0) ? 32'h40 + 32'($urandom_range(0, 7) * 4) : NO_END;
            max_cycles_i = ($urandom_range(0, 1) == 0) ? 0 : 32'($urandom_range(1, 40));
            do_reset();
            pc = 32'h40;
            for (int c = 0; c < 50; c++) begin
                if ($urandom_range(0, 1) == 0) pc = 32'h40 + 32'($urandom_range(0, 11) * 4);
                step(pc, $urandom_range(0, 3) != 0);
                idx = $urandom_range(0, HD - 1);
                hist_idx_i = 3'(idx); #1;
                n_checks++;
                if (status_o !== 2'(m_status) || done_o !== (m_status != 0) || cycle_cnt_o !== m_cyc ||
                    pc_chg_cnt_o !== m_chg || last_pc_o !== m_last || hist_cnt_o !== 4'(m_hist.size()) ||
                    hist_pc_o !== model_hist(idx)) begin
                    n_fail++;
                    $display("FAIL rand run%0d cyc%0d: got st=%0b cyc=%0d chg=%0d last=%h hcnt=%0d h[%0d]=%h want st=%0d cyc=%0d chg=%0d last=%h hcnt=%0d h=%h",
                             run, c, status_o, cycle_cnt_o, pc_chg_cnt_o, last_pc_o, hist_cnt_o, idx, hist_pc_o,
                             m_status, m_cyc, m_chg, m_last, m_hist.size(), model_hist(idx));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_end_hit();
        test_loop_halt();
        test_timeout_bubbles();
        test_priority();
        test_history_wrap();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
